// File: rtl/fixed_point_fir_mac.sv
// fixed_point_fir_mac: time-multiplexed fixed-point FIR, one MAC per cycle, round + saturate, valid/ready out
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready     sample handshake (in_ready only while IDLE)
//   in_data               signed input sample x[n]
//   coef_we/addr/data     coefficient bank write port (honoured only while IDLE)
//   out_valid/out_ready   result handshake (out_valid only while OUT)
//   out_data, out_sat     rounded/saturated y[n] and its clip flag
`timescale 1ns/1ps
module fixed_point_fir_mac #(
    parameter int X_WORD_LEN = 8,
    parameter int X_FRAC_LEN = 6,
    parameter int H_WORD_LEN = 8,
    parameter int H_FRAC_LEN = 7,
    parameter int Y_WORD_LEN = 10,
    parameter int Y_FRAC_LEN = 6,
    parameter int TAPS = 8,
    localparam int AW = $clog2(TAPS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [X_WORD_LEN-1:0] in_data,
    input  logic                         coef_we,
    input  logic [AW-1:0]                coef_addr,
    input  logic signed [H_WORD_LEN-1:0] coef_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [Y_WORD_LEN-1:0] out_data,
    output logic                         out_sat
);
    localparam int P_W = X_WORD_LEN + H_WORD_LEN;
    localparam int ACC_W = P_W + AW;
    localparam int S = X_FRAC_LEN + H_FRAC_LEN - Y_FRAC_LEN;
    localparam int SR = S > 0 ? S : 0;
    localparam int L = S < 0 ? -S : 0;
    // one spare bit keeps the rounding add from overflowing; L bits absorb a left shift
    localparam int C_W = ACC_W + L + 1;
    localparam logic signed [C_W-1:0] HALF = S > 0 ? C_W'(1) <<< (SR > 0 ? SR - 1 : 0) : '0;
    localparam logic signed [C_W-1:0] Y_MAX = C_W'((64'sd1 <<< (Y_WORD_LEN - 1)) - 64'sd1);
    localparam logic signed [C_W-1:0] Y_MIN = ~Y_MAX;
    localparam logic [AW-1:0] K_LAST = AW'(TAPS - 1);
    localparam logic [AW-1:0] TAPS_A = AW'(TAPS);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
    state_t state, state_nxt;

    logic signed [X_WORD_LEN-1:0] x_buf [TAPS];
    logic signed [H_WORD_LEN-1:0] h [TAPS];
    logic [AW-1:0] wr_ptr, newest, k, idx;
    logic signed [ACC_W-1:0] acc, acc_nxt;
    logic signed [P_W-1:0] prod;
    logic signed [C_W-1:0] ext, conv;
    logic sat_hi, sat_lo;
    logic signed [Y_WORD_LEN-1:0] y;

    // (newest - k) mod TAPS; the wrapped branch is exact in AW bits since the true value < TAPS
    assign idx = newest >= k ? newest - k : newest - k + TAPS_A;
    assign prod = x_buf[idx] * h[k];
    assign acc_nxt = acc + ACC_W'(prod);
    assign ext = C_W'(acc_nxt);
    // HALF is zero and SR/L collapse to no-ops when the corresponding shift is not needed
    assign conv = ((ext + HALF) >>> SR) <<< L;
    assign sat_hi = conv > Y_MAX;
    assign sat_lo = conv < Y_MIN;
    assign y = sat_hi ? Y_MAX[Y_WORD_LEN-1:0] : sat_lo ? Y_MIN[Y_WORD_LEN-1:0] : conv[Y_WORD_LEN-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = state == IDLE;
        out_valid = state == OUT;
        state_nxt = state == IDLE ? (in_valid ? MAC : IDLE)
                  : state == MAC  ? (k == K_LAST ? OUT : MAC)
                  : (out_ready ? IDLE : OUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                x_buf[i] <= '0;
                h[i]     <= '0;
            end
            wr_ptr   <= '0;
            newest   <= '0;
            k        <= '0;
            acc      <= '0;
            out_data <= '0;
            out_sat  <= 1'b0;
        end else begin
            if (state == IDLE && coef_we) h[coef_addr] <= coef_data;
            if (state == IDLE && in_valid) begin
                x_buf[wr_ptr] <= in_data;
                newest        <= wr_ptr;
                wr_ptr        <= wr_ptr == K_LAST ? '0 : wr_ptr + 1'b1;
                acc           <= '0;
                k             <= '0;
            end
            if (state == MAC) begin
                acc <= acc_nxt;
                k   <= k + 1'b1;
                // final term and conversion land together on the last MAC edge
                if (k == K_LAST) begin
                    out_data <= y;
                    out_sat  <= sat_hi | sat_lo;
                end
            end
        end
    end
endmodule

// File: tb/tb_fixed_point_fir_mac.sv
// tb_fixed_point_fir_mac: table-driven, scoreboarded bench for fixed_point_fir_mac
`timescale 1ns/1ps
module tb_fixed_point_fir_mac;
    logic clk = 0;
    logic rst = 1;
    logic in_valid = 0;
    logic in_ready;
    logic signed [7:0] in_data = 0;
    logic coef_we = 0;
    logic [2:0] coef_addr = 0;
    logic signed [7:0] coef_data = 0;
    logic out_valid;
    logic out_ready = 1;
    logic signed [9:0] out_data;
    logic out_sat;

    fixed_point_fir_mac dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [7:0] x;
        logic signed [9:0] y;
        logic s;
    } vec_t;
    typedef struct packed {
        logic signed [9:0] y;
        logic s;
    } exp_t;

    vec_t tv [10];
    exp_t sb [$];
    int total = 0;
    int bad = 0;

    task automatic check(input string name, input int act, input int want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output got=%0d want=none", out_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_data", out_data, e.y);
                check("out_sat", out_sat, e.s);
            end
        end
    end

    task automatic set_vec(input int i, input int x, input int y, input int s);
        tv[i].x = 8'(x);
        tv[i].y = 10'(y);
        tv[i].s = s[0];
    endtask

    task automatic do_reset();
        in_valid = 0;
        coef_we = 0;
        out_ready = 1;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic write_coef(input int a, input int v);
        coef_we = 1;
        coef_addr = 3'(a);
        coef_data = 8'(v);
        @(posedge clk);
        #1 coef_we = 0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1 lat++;
        end
        if (!out_valid) check("out_valid_timeout", out_valid, 1);
        if (out_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int x, input int y, input int s, output int lat,
                        input logic cw = 0, input int ca = 0, input int cd = 0);
        int n = 0;
        sb.push_back('{10'(y), s[0]});
        in_valid = 1;
        in_data = 8'(x);
        coef_we = cw;
        coef_addr = 3'(ca);
        coef_data = 8'(cd);
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        @(posedge clk);
        #1;
        in_valid = 0;
        coef_we = 0;
        wait_out(lat);
    endtask

    task automatic run_table(input int n);
        int lat;
        for (int i = 0; i < n; i++) begin
            send(tv[i].x, tv[i].y, tv[i].s, lat);
            check("latency", lat, 8);
        end
    endtask

    task automatic load_coefs_ramp();
        for (int i = 0; i < 8; i++) write_coef(i, i + 1);
    endtask

    task automatic load_impulse();
        for (int i = 0; i < 8; i++) set_vec(i, i == 0 ? 64 : 0, i / 2 + 1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int lat;
        do_reset();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_in_ready", in_ready, 1);

        load_coefs_ramp();
        load_impulse();
        run_table(8);

        do_reset();
        for (int i = 0; i < 8; i++) write_coef(i, 16);
        for (int i = 0; i < 10; i++) set_vec(i, 64, 8 * (i < 8 ? i + 1 : 8), 0);
        run_table(10);

        do_reset();
        for (int i = 0; i < 8; i++) write_coef(i, 127);
        set_vec(0, 127, 126, 0);
        set_vec(1, 127, 252, 0);
        set_vec(2, 127, 378, 0);
        set_vec(3, 127, 504, 0);
        for (int i = 4; i < 8; i++) set_vec(i, 127, 511, 1);
        run_table(8);

        do_reset();
        for (int i = 0; i < 8; i++) write_coef(i, 127);
        set_vec(0, -128, -127, 0);
        set_vec(1, -128, -254, 0);
        set_vec(2, -128, -381, 0);
        set_vec(3, -128, -508, 0);
        for (int i = 4; i < 8; i++) set_vec(i, -128, -512, 1);
        run_table(8);

        do_reset();
        load_coefs_ramp();
        out_ready = 0;
        send(64, 1, 0, lat);
        check("bp_latency", lat, 8);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0] == 1'b0;
            in_data = 100;
            @(posedge clk);
            #1;
            check("bp_out_valid", out_valid, 1);
            check("bp_out_data", out_data, 1);
            check("bp_in_ready", in_ready, 0);
        end
        in_valid = 0;
        out_ready = 1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 7; i++) set_vec(i, 0, (i + 1) / 2 + 1, 0);
        run_table(7);

        do_reset();
        load_coefs_ramp();
        sb.push_back('{10'sd1, 1'b0});
        in_valid = 1;
        in_data = 64;
        @(posedge clk);
        #1;
        in_valid = 0;
        coef_we = 1;
        coef_addr = 0;
        coef_data = 100;
        @(posedge clk);
        #1 coef_we = 0;
        wait_out(lat);
        check("gate_latency", lat, 7);
        send(64, 2, 0, lat);
        send(64, 53, 0, lat, 1'b1, 0, 100);

        in_valid = 1;
        in_data = 64;
        @(posedge clk);
        #1;
        in_valid = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("hold_during_mac", out_data, 53);
        @(posedge clk);
        rst = 1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_out_sat", out_sat, 0);
        @(posedge clk);
        #1 rst = 0;
        check("midrst_in_ready", in_ready, 1);
        load_coefs_ramp();
        load_impulse();
        run_table(8);

        repeat (3) @(posedge clk);
        check("sb_pending", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
